epp_bram_bridge: RTL and testbench

Parametrised EPP-to-block-RAM bridge: connects the EPP controller's data strobe, address register and data buses to one to four BRAM banks through an auto-incrementing address pointer. It replaces the asynchronous strobe-clocked bridge. All logic runs on `clk`: the strobe is synchronised, edge-detected and sequenced by a small FSM. Adds configurable address width, bank selection, up/down auto-increment, a wrap flag and a busy indication.

---
 rtl/epp_bram_pkg.sv | 27 ++
 rtl/epp_bram_bridge_if.sv | 25 ++
 rtl/epp_strobe_sync.sv | 20 ++
 rtl/epp_bram_bridge.sv | 91 +++++++++
 tb/tb_epp_bram_bridge.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/epp_bram_pkg.sv
// epp_bram_pkg: shared region codes, register bit positions and FSM states for the EPP BRAM bridge
package epp_bram_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'b00,
        REG_ADDR   = 2'b01,
        REG_CTRL   = 2'b10,
        REG_STATUS = 2'b11
    } region_t;

    localparam int CTRL_INC  = 0;
    localparam int CTRL_DIR  = 1;
    localparam int CTRL_BANK = 2;
    localparam int STAT_BUSY = 0;
    localparam int STAT_WRAP = 1;

    localparam logic [3:0] CTRL_RST = 4'h1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_COMMIT,
        S_SETTLE1,
        S_SETTLE2
    } state_t;

endpackage

// File: rtl/epp_bram_bridge_if.sv
// epp_bram_bridge_if: EPP host bus and BRAM bank bus seen by the bridge
interface epp_bram_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int NBANKS = 2
);
    logic                  stb_data;
    logic                  ctrl_wr;
    logic [7:0]            epp_in;
    logic [7:0]            epp_addr_in;
    logic [7:0]            epp_out;
    logic [ADDR_W-1:0]     bram_addr;
    logic [7:0]            bram_wdata;
    logic [NBANKS-1:0]     bram_we;
    logic [8*NBANKS-1:0]   bram_rdata;

    modport master (
        output stb_data, ctrl_wr, epp_in, epp_addr_in, bram_rdata,
        input  epp_out, bram_addr, bram_wdata, bram_we
    );

    modport slave (
        input  stb_data, ctrl_wr, epp_in, epp_addr_in, bram_rdata,
        output epp_out, bram_addr, bram_wdata, bram_we
    );
endinterface

// File: rtl/epp_strobe_sync.sv
// epp_strobe_sync: two-flop synchroniser for the async strobe plus rise/fall detect, idle-high after reset
module epp_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    output logic rise,
    output logic fall
);
    logic [2:0] sr;

    always_ff @(posedge clk) begin
        if (rst)
            sr <= 3'b111;
        else
            sr <= {sr[1:0], stb};
    end

    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/epp_bram_bridge.sv
// epp_bram_bridge: EPP data-strobe bridge to up to four BRAM banks through an auto-adjusting pointer
module epp_bram_bridge
    import epp_bram_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int NBANKS = 2
) (
    input logic clk,
    input logic rst,
    epp_bram_bridge_if.slave bus
);
    state_t            state, state_n;
    region_t           region;
    logic              pend, pend_n, wrap, wrap_n, rise, fall, busy, commit, host_wr;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [3:0]        ctrl, ctrl_n, we4;
    logic [7:0]        rdata_q;
    logic [15:0]       ptr16, hi16;
    logic [31:0]       rd_pad;

    epp_strobe_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .stb  (bus.stb_data),
        .rise (rise),
        .fall (fall)
    );

    assign region  = region_t'(bus.epp_addr_in[7:6]);
    assign busy    = state inside {S_COMMIT, S_SETTLE1, S_SETTLE2};
    assign commit  = state == S_COMMIT;
    assign host_wr = commit && !bus.ctrl_wr;
    assign ptr16   = 16'(ptr);
    assign hi16    = {bus.epp_in, ptr16[7:0]};
    // Zero-padding to four banks makes out-of-range bank indices read 0 and write nothing.
    assign rd_pad  = 32'(bus.bram_rdata);
    assign we4     = (host_wr && region == REG_DATA && !rst) ? 4'b0001 << ctrl[CTRL_BANK+:2] : 4'b0000;

    always_comb begin
        state_n = state;
        pend_n  = pend | (busy & fall);
        ptr_n   = ptr;
        ctrl_n  = ctrl;
        wrap_n  = wrap;
        case (state)
            S_IDLE:    state_n = fall ? S_ACTIVE : S_IDLE;
            S_ACTIVE:  state_n = rise ? S_COMMIT : S_ACTIVE;
            S_COMMIT:  state_n = S_SETTLE1;
            S_SETTLE1: state_n = S_SETTLE2;
            default:   state_n = (pend | fall) ? S_ACTIVE : S_IDLE;
        endcase
        if (state_n == S_ACTIVE && state != S_ACTIVE)
            pend_n = 1'b0;
        if (commit && region == REG_DATA && ctrl[CTRL_INC]) begin
            ptr_n  = ctrl[CTRL_DIR] ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
            wrap_n = wrap | (ctrl[CTRL_DIR] ? ~|ptr : &ptr);
        end
        if (host_wr && region == REG_ADDR) begin
            ptr_n  = bus.epp_addr_in[0] ? ADDR_W'(hi16) : {ptr[ADDR_W-1:8], bus.epp_in};
            wrap_n = 1'b0;
        end
        if (host_wr && region == REG_CTRL)
            ctrl_n = bus.epp_in[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pend    <= 1'b0;
            ptr     <= '0;
            ctrl    <= CTRL_RST;
            wrap    <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            ptr     <= ptr_n;
            ctrl    <= ctrl_n;
            wrap    <= wrap_n;
            rdata_q <= rd_pad[{ctrl[CTRL_BANK+:2], 3'b000} +: 8];
        end
    end

    assign bus.bram_addr  = ptr;
    assign bus.bram_wdata = bus.epp_in;
    assign bus.bram_we    = NBANKS'(we4);
    assign bus.epp_out    = region == REG_DATA ? rdata_q :
                            region == REG_ADDR ? (bus.epp_addr_in[0] ? ptr16[15:8] : ptr16[7:0]) :
                            region == REG_CTRL ? {4'h0, ctrl} :
                            (8'(wrap) << STAT_WRAP) | (8'(busy) << STAT_BUSY);
endmodule

// File: tb/tb_epp_bram_bridge.sv
// tb_epp_bram_bridge: randomized scoreboard bench for epp_bram_bridge against a behavioural model
module tb_epp_bram_bridge;
    localparam int AW = 12;
    localparam int NB = 2;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int bank;
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int errors = 0;
    int checks = 0;
    wr_t exp_wr[$];
    int exp_rd[$];
    event rd_ev;
    logic [7:0] bram [NB][DEPTH];
    logic [7:0] ref_mem [NB][DEPTH];
    int m_ptr;
    logic [3:0] m_ctrl;
    bit m_wrap;
    logic [1:0] r;
    logic [7:0] ra;

    epp_bram_bridge_if #(.ADDR_W(AW), .NBANKS(NB)) bus ();
    epp_bram_bridge #(.ADDR_W(AW), .NBANKS(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int init_byte(input int b, input int i);
        return ((i * 37) ^ (b * 91) ^ (i >> 5)) & 255;
    endfunction

    // BRAM banks: registered read, write on bram_we
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_init)
                for (int i = 0; i < DEPTH; i++) bram[b][i] <= 8'(init_byte(b, i));
            else if (bus.bram_we[b])
                bram[b][bus.bram_addr] <= bus.bram_wdata;
            bus.bram_rdata[8*b +: 8] <= bram[b][bus.bram_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int model_read(input logic [7:0] a, input bit busy);
        int b = int'(m_ctrl[3:2]);
        case (a[7:6])
            2'd0:    return b < NB ? int'(ref_mem[b][m_ptr]) : 0;
            2'd1:    return a[0] ? m_ptr / 256 : m_ptr % 256;
            2'd2:    return int'(m_ctrl);
            default: return (m_wrap ? 2 : 0) + (busy ? 1 : 0);
        endcase
    endfunction

    function automatic void model_commit(input bit rd, input logic [7:0] a, input logic [7:0] d);
        int b = int'(m_ctrl[3:2]);
        case (a[7:6])
            2'd0: begin
                if (!rd && b < NB) begin
                    exp_wr.push_back('{b, m_ptr, int'(d)});
                    ref_mem[b][m_ptr] = d;
                end
                if (m_ctrl[0]) begin
                    if (m_ctrl[1]) begin
                        m_wrap = m_wrap || m_ptr == 0;
                        m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                    end else begin
                        m_wrap = m_wrap || m_ptr == DEPTH - 1;
                        m_ptr = (m_ptr + 1) % DEPTH;
                    end
                end
            end
            2'd1: if (!rd) begin
                m_ptr = a[0] ? m_ptr % 256 + (int'(d) * 256) % DEPTH : m_ptr - m_ptr % 256 + int'(d);
                m_wrap = 0;
            end
            2'd2: if (!rd) m_ctrl = d[3:0];
            default: ;
        endcase
    endfunction

    // One host strobe cycle; reads are sampled just before the strobe rises.
    task automatic epp_cycle(input bit rd, input logic [7:0] a, input logic [7:0] d,
                             input int low, input int gap);
        int e = model_read(a, 1'b0);
        @(negedge clk);
        bus.ctrl_wr = rd;
        bus.epp_addr_in = a;
        bus.epp_in = d;
        bus.stb_data = 1'b0;
        tick(low);
        if (rd) begin
            exp_rd.push_back(e);
            ->rd_ev;
        end
        bus.stb_data = 1'b1;
        model_commit(rd, a, d);
        tick(gap);
        chk("ptr", int'(bus.bram_addr), m_ptr);
        chk("wr_drain", exp_wr.size(), 0);
    endtask

    always begin : wr_mon
        wr_t w;
        @(negedge clk);
        #1;
        if (bus.bram_we != '0) begin
            if (exp_wr.size() == 0)
                chk("unexpected_we", int'(bus.bram_we), 0);
            else begin
                w = exp_wr.pop_front();
                chk("we", int'(bus.bram_we), 1 << w.bank);
                chk("waddr", int'(bus.bram_addr), w.addr);
                chk("wdata", int'(bus.bram_wdata), w.data);
            end
        end
    end

    always begin : rd_mon
        @(rd_ev);
        chk("epp_out", int'(bus.epp_out), exp_rd.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.stb_data = 1'b1;
        bus.ctrl_wr = 1'b1;
        bus.epp_addr_in = 8'h00;
        bus.epp_in = 8'h00;
        m_ptr = 0;
        m_ctrl = 4'h1;
        m_wrap = 0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < DEPTH; i++) ref_mem[b][i] = 8'(init_byte(b, i));
        tick(3);
        mem_init = 1'b0;
        chk("rst_epp_out", int'(bus.epp_out), 0);
        chk("rst_we", int'(bus.bram_we), 0);
        chk("rst_addr", int'(bus.bram_addr), 0);
        bus.epp_addr_in = 8'h80;
        #1 chk("rst_ctrl", int'(bus.epp_out), 1);
        bus.epp_addr_in = 8'hC0;
        #1 chk("rst_status", int'(bus.epp_out), 0);
        bus.epp_addr_in = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        tick(3);

        epp_cycle(0, 8'h40, 8'h34, 2, 6);
        epp_cycle(0, 8'h41, 8'h02, 2, 6);
        chk("ptr_0x234", int'(bus.bram_addr), 'h234);
        epp_cycle(0, 8'h00, 8'hA5, 3, 6);
        chk("ptr_0x235", int'(bus.bram_addr), 'h235);

        epp_cycle(0, 8'h40, 8'hFF, 2, 6);
        epp_cycle(0, 8'h41, 8'h0F, 2, 6);
        epp_cycle(1, 8'h41, 8'h00, 2, 6);
        epp_cycle(0, 8'h00, 8'h11, 2, 6);
        chk("wrap_ptr", int'(bus.bram_addr), 0);
        epp_cycle(1, 8'hC0, 8'h00, 2, 6);
        epp_cycle(0, 8'h40, 8'h00, 2, 6);
        epp_cycle(1, 8'hC0, 8'h00, 2, 6);

        epp_cycle(0, 8'h80, 8'h03, 2, 6);
        epp_cycle(1, 8'h00, 8'h00, 3, 6);
        chk("down_ptr", int'(bus.bram_addr), 'hFFF);
        epp_cycle(1, 8'hC0, 8'h00, 2, 6);

        epp_cycle(0, 8'h80, 8'h04, 2, 6);
        epp_cycle(0, 8'h00, 8'h5A, 2, 6);
        epp_cycle(0, 8'h80, 8'h0D, 2, 6);
        epp_cycle(0, 8'h00, 8'h66, 2, 6);
        epp_cycle(1, 8'h00, 8'h00, 2, 6);
        epp_cycle(0, 8'h80, 8'h01, 2, 6);

        // Back-to-back: second fall lands in SETTLE1, STATUS polled in the second SETTLE2
        @(negedge clk);
        bus.ctrl_wr = 1'b0;
        bus.epp_addr_in = 8'h00;
        bus.epp_in = 8'hC3;
        bus.stb_data = 1'b0;
        tick(2);
        bus.stb_data = 1'b1;
        model_commit(0, 8'h00, 8'hC3);
        tick(2);
        bus.stb_data = 1'b0;
        tick(2);
        bus.epp_in = 8'h3C;
        tick(3);
        bus.stb_data = 1'b1;
        model_commit(0, 8'h00, 8'h3C);
        tick(4);
        bus.ctrl_wr = 1'b1;
        bus.epp_addr_in = 8'hC0;
        tick(1);
        exp_rd.push_back(model_read(8'hC0, 1'b1));
        ->rd_ev;
        tick(6);
        chk("b2b_ptr", int'(bus.bram_addr), m_ptr);
        chk("b2b_drain", exp_wr.size(), 0);

        // Reset during COMMIT of a write aborts it
        @(negedge clk);
        bus.ctrl_wr = 1'b0;
        bus.epp_addr_in = 8'h00;
        bus.epp_in = 8'h77;
        bus.stb_data = 1'b0;
        tick(2);
        bus.stb_data = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        m_ptr = 0;
        m_ctrl = 4'h1;
        m_wrap = 0;
        chk("abort_ptr", int'(bus.bram_addr), 0);
        bus.ctrl_wr = 1'b1;
        bus.epp_addr_in = 8'h80;
        #1 chk("abort_ctrl", int'(bus.epp_out), 1);
        bus.epp_addr_in = 8'hC0;
        #1 chk("abort_status", int'(bus.epp_out), 0);
        tick(4);

        for (int n = 0; n < 120; n++) begin
            r = ($urandom_range(0, 9) < 5) ? 2'd0 : 2'($urandom_range(1, 3));
            ra = {r, 5'($urandom), 1'($urandom)};
            epp_cycle(1'($urandom), ra, 8'($urandom), $urandom_range(2, 4), $urandom_range(6, 8));
        end

        tick(4);
        chk("final_wr_queue", exp_wr.size(), 0);
        chk("final_rd_queue", exp_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
